// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave that turns command/address/data frames into single-cycle
// write and read strobes on a local register bus, with burst auto-increment.
module spi_slave_bridge #(
  parameter int unsigned      CMD_W      = 8,
  parameter int unsigned      ADDR_W     = 24,
  parameter int unsigned      DATA_W     = 32,
  parameter logic [CMD_W-1:0] WR_CMD     = 8'hA4,
  parameter logic [CMD_W-1:0] RD_CMD     = 8'hA5,
  parameter int unsigned      DUMMY_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs,
  input  logic              copi,
  output logic              cipo,
  output logic              cipo_oe,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_address_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_address_out,
  input  logic [DATA_W-1:0] rd_data_in,
  input  logic              rd_valid_in,
  output logic              err_out
);

  localparam int unsigned SH_A = (CMD_W > ADDR_W) ? CMD_W : ADDR_W;
  localparam int unsigned SH_W = (SH_A > DATA_W) ? SH_A : DATA_W;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_DRAIN
  } state_e;

  state_e            state_q;
  logic [1:0]        sck_sync_q, cs_sync_q, copi_sync_q;
  logic              sck_prev_q, cs_prev_q, armed_q, is_wr_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [SH_W-2:0]   in_sh_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q, hold_q, out_sh_q;
  logic              hold_vld_q, rd_pend_q;
  logic              cipo_q, cipo_oe_q, wr_en_q, rd_en_q, err_q;

  logic sck_s, cs_s, copi_s, sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SH_W-1:0] sh_d;
  logic cmd_hit, last_bit, abort_err;

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign copi_s   = copi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sh_d     = {in_sh_q, copi_s};
  assign cmd_hit  = (sh_d[CMD_W-1:0] == WR_CMD) || (sh_d[CMD_W-1:0] == RD_CMD);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_CMD:            last_bit = (bit_cnt_q == CNT_W'(CMD_W - 1));
      S_ADDR:           last_bit = (bit_cnt_q == CNT_W'(ADDR_W - 1));
      S_DUMMY:          last_bit = (bit_cnt_q == CNT_W'(DUMMY_BITS - 1));
      S_WDATA, S_RDATA: last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));
      default:          last_bit = 1'b0;
    endcase
  end

  // A cs rise is an error unless, after any bit landing in the same clk, the frame sits on a clean boundary.
  always_comb begin
    abort_err = 1'b0;
    case (state_q)
      S_CMD:            abort_err = !(sck_rise && last_bit && !cmd_hit);
      S_ADDR:           abort_err = !(sck_rise && last_bit && (is_wr_q || DUMMY_BITS == 0));
      S_DUMMY:          abort_err = !(sck_rise && last_bit);
      S_WDATA, S_RDATA: abort_err = sck_rise ? !last_bit : (bit_cnt_q != '0);
      default:          abort_err = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; a later assignment in this block overrides an earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      copi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      bit_cnt_q   <= '0;
      in_sh_q     <= '0;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_data_q   <= '0;
      hold_q      <= '0;
      out_sh_q    <= '0;
      hold_vld_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      cs_sync_q   <= {cs_sync_q[0], cs};
      copi_sync_q <= {copi_sync_q[0], copi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      armed_q     <= armed_q | cs_s;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      err_q       <= 1'b0;

      if (rd_valid_in && rd_pend_q) begin
        hold_q     <= rd_data_in;
        hold_vld_q <= 1'b1;
        rd_pend_q  <= 1'b0;
      end

      if (sck_rise) begin
        in_sh_q   <= sh_d[SH_W-2:0];
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        if (last_bit) begin
          bit_cnt_q <= '0;
          case (state_q)
            S_CMD: begin
              is_wr_q <= (sh_d[CMD_W-1:0] == WR_CMD);
              state_q <= cmd_hit ? S_ADDR : S_DRAIN;
            end
            S_ADDR: begin
              addr_q <= sh_d[ADDR_W-1:0];
              if (is_wr_q) begin
                state_q <= S_WDATA;
              end else begin
                rd_en_q    <= 1'b1;
                rd_addr_q  <= sh_d[ADDR_W-1:0];
                rd_pend_q  <= 1'b1;
                hold_vld_q <= 1'b0;
                if (DUMMY_BITS == 0) begin
                  state_q   <= S_RDATA;
                  cipo_oe_q <= 1'b1;
                end else begin
                  state_q <= S_DUMMY;
                end
              end
            end
            S_DUMMY: begin
              state_q   <= S_RDATA;
              cipo_oe_q <= 1'b1;
            end
            S_WDATA: begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= sh_d[DATA_W-1:0];
              addr_q    <= addr_q + ADDR_W'(1);
            end
            S_RDATA: begin
              // Prefetch the next word as soon as the current one has been clocked out.
              rd_en_q    <= 1'b1;
              rd_addr_q  <= addr_q + ADDR_W'(1);
              addr_q     <= addr_q + ADDR_W'(1);
              rd_pend_q  <= 1'b1;
              hold_vld_q <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      if (sck_fall && state_q == S_RDATA) begin
        if (bit_cnt_q == '0) begin
          if (hold_vld_q) begin
            cipo_q   <= hold_q[DATA_W-1];
            out_sh_q <= hold_q << 1;
          end else begin
            cipo_q   <= 1'b0;
            out_sh_q <= '0;
            err_q    <= 1'b1;
          end
          hold_vld_q <= 1'b0;
          rd_pend_q  <= 1'b0;
        end else begin
          cipo_q   <= out_sh_q[DATA_W-1];
          out_sh_q <= out_sh_q << 1;
        end
      end

      if (cs_rise) begin
        state_q   <= S_IDLE;
        cipo_q    <= 1'b0;
        cipo_oe_q <= 1'b0;
        if (abort_err) err_q <= 1'b1;
      end else if (cs_fall && armed_q && state_q == S_IDLE) begin
        state_q   <= S_CMD;
        bit_cnt_q <= '0;
      end
    end
  end

  assign cipo           = cipo_q;
  assign cipo_oe        = cipo_oe_q;
  assign wr_en_out      = wr_en_q;
  assign wr_address_out = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign rd_en_out      = rd_en_q;
  assign rd_address_out = rd_addr_q;
  assign err_out        = err_q;

endmodule

// File: doc/spi_slave_bridge.md
# spi_slave_bridge

Parametrised SPI slave (mode 0) that turns framed command/address/data transactions into single-cycle write and read strobes on a local register bus. It succeeds the fixed 8/24/32-bit write-only SPI receiver. It adds configurable field widths, a read command with dummy turnaround and `cipo` shift-out, burst auto-increment, and abort/error reporting. SPI pins are asynchronous to the system clock and are oversampled inside the block.

## Interface
- `CMD_W`, 8: command field width, bits.
- `ADDR_W`, 24: address field width, bits.
- `DATA_W`, 32: data word width, bits; a multiple of 8.
- `WR_CMD`, 8'hA4: write command code.
- `RD_CMD`, 8'hA5: read command code.
- `DUMMY_BITS`, 8: turnaround bits between address and read data; 0 is allowed.
- `clk` input 1: system clock; must be ≥ 8× `sck` frequency.
- `rst` input 1: synchronous, active-high reset.
- `sck` input 1: SPI clock, async.
- `cs` input 1: chip select, active low, async.
- `copi` input 1: serial data in, MSB first, async.
- `cipo` output 1: serial data out.
- `cipo_oe` output 1: output enable for `cipo`.
- `wr_en_out` output 1: one-`clk` write strobe.
- `wr_address_out` output ADDR_W: write address.
- `wr_data_out` output DATA_W: write data.
- `rd_en_out` output 1: one-`clk` read request.
- `rd_address_out` output ADDR_W: read address.
- `rd_data_in` input DATA_W: read data.
- `rd_valid_in` input 1: `rd_data_in` is valid this cycle.
- `err_out` output 1: one-`clk` error pulse.

## Operation
- `sck`, `cs` and `copi` each pass through a 2-FF synchronizer, then a 1-FF edge detector.
- `copi` is sampled on the detected `sck` rising edge. `cipo` is updated on the detected falling edge.
- FSM states: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, DRAIN.
- IDLE → CMD when synced `cs` falls. Bit counter is cleared.
- CMD → ADDR after CMD_W bits, when the command equals WR_CMD or RD_CMD.
- CMD → DRAIN after CMD_W bits for any other code. DRAIN ignores bits until `cs` goes high and produces no strobes.
- ADDR → WDATA (write) after ADDR_W bits.
- ADDR → RDATA (read), after ADDR_W bits, when DUMMY_BITS=0.
- ADDR → DUMMY (read), after ADDR_W bits, when DUMMY_BITS>0.
- DUMMY → RDATA after DUMMY_BITS bits.
- Read requests:
  - `rd_en_out` pulses on the clk after the last address bit, with `rd_address_out` = address.
  - `rd_data_in` is captured into a holding register on the first `rd_valid_in`.
  - The holding register is loaded into the shift register at word start.
- WDATA: after each DATA_W bits, `wr_en_out` pulses with the current address and the assembled word. The address then increments by 1 and the bit counter is cleared (burst).
- RDATA: after DATA_W bits shifted out, the address increments and the next `rd_en_out` is issued at once (prefetch).
- Address arithmetic is modulo 2^ADDR_W, so all-ones wraps to 0.
- `cipo_oe` is 1 only in RDATA while `cs` is low. Otherwise it is 0 and `cipo` = 0.
- Any state → IDLE on synced `cs` rise. A partial data word is discarded, with no strobe.
- `err_out` pulses on:
  - `cs` rising in CMD, ADDR or DUMMY, or mid-word in WDATA/RDATA;
  - a read word starting with no `rd_valid_in` received since its `rd_en_out`. That word shifts out as zeros.
- An unknown command (DRAIN) is not an error.

## Timing
- Reset values: every output is 0. The FSM goes to IDLE and the counters and holding register clear.
- After reset, a frame is accepted only once `cs` has been seen high. Reset asserted mid-frame therefore ignores the rest of that frame.
- Pin-to-edge-detect latency: 3 clk.
- `wr_en_out` is asserted 1 clk after the detected rising edge of the last data bit.
- `wr_address_out` and `wr_data_out` are updated in the same cycle as `wr_en_out` and hold until the next strobe.
- `rd_en_out` and `rd_address_out` follow the same timing as the write strobe.
- `rd_valid_in` deadline: before the falling `sck` edge that presents the word's MSB.
  - With DUMMY_BITS=8, this allows ≥ 8 `sck` periods.
  - With DUMMY_BITS=0, it allows about half an `sck` period minus 3 clk.
- When a detected `sck` rise and a detected `cs` rise occur in the same clk, the bit is processed first and then the abort is applied. If that bit completes a word, the strobe still fires.
- Strobes are never back-to-back: the minimum spacing is DATA_W `sck` periods.

## Test plan
- Write at 8× oversampling: `cs` low, A4 12 34 56 DE AD BE EF, `cs` high → exactly one `wr_en_out`, address 24'h123456, data 32'hDEADBEEF, `err_out` 0.
- Burst write: A4 12 34 56 followed by 8 data bytes DEADBEEF CAFEF00D → two strobes, address 123456 then 123457, with the matching data words.
- Unknown command: A1 12 34 56 DE AD BE EF → no `wr_en_out`, no `rd_en_out`, no `err_out`, `cipo_oe` stays 0.
- Read with wrap: A5 FF FF FF, 8 dummy bits, 64 clocks; host answers 11223344 and then 55667788 with a 2 clk delay:
  - `rd_en_out` is issued at FFFFFF and then 000000.
  - `cipo` shifts out 11223344 55667788, MSB first.
- Aborts and late data:
  - Write frame with `cs` raised after 20 data bits → no `wr_en_out`, one `err_out` pulse.
  - Read frame where `rd_valid_in` is never asserted → `cipo` shifts out zeros, one `err_out` pulse.
- Reset mid-frame: assert `rst` during the address phase, release it, finish that frame → no strobes. The next full write frame produces a correct strobe.
